// File: rtl/raccolta_mosse.sv
// Collects one move from each of two players, holds the pair until the downstream stage accepts it.
// A missing move forfeits as 00 after TIMEOUT_CICLI cycles of waiting.
module raccolta_mosse #(
    parameter logic [15:0] TIMEOUT_CICLI = 16'd1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] MOSSA_P1,
    input  logic       VALIDO_P1,
    input  logic [1:0] MOSSA_P2,
    input  logic       VALIDO_P2,
    input  logic       ANNULLA,
    input  logic       PRONTO,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       USCITA_VALIDA,
    output logic       ATTESA_P1,
    output logic       ATTESA_P2,
    output logic       TIMEOUT,
    output logic [4:0] CONTA_MOSSE
);

    localparam int unsigned MOSSA_W = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned CONTA_W = 5;
    localparam logic [CONTA_W-1:0] CONTA_MAX = CONTA_W'(31);
    localparam logic [CNT_W-1:0]   SCADENZA  = CNT_W'(TIMEOUT_CICLI - 16'd1);

    typedef enum logic [1:0] {
        VUOTO    = 2'd0,
        SOLO_P1  = 2'd1,
        SOLO_P2  = 2'd2,
        COMPLETO = 2'd3
    } stato_t;

    stato_t               stato_q, stato_d;
    logic [MOSSA_W-1:0]   reg1_q, reg1_d, reg2_q, reg2_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CONTA_W-1:0]   conta_d;
    logic                 timeout_d;
    logic                 v1, v2;

    assign v1 = VALIDO_P1 && (MOSSA_P1 != 2'b00);
    assign v2 = VALIDO_P2 && (MOSSA_P2 != 2'b00);

    // Next-state, move registers, forfeit counter and transfer count
    always_comb begin
        stato_d   = stato_q;
        reg1_d    = reg1_q;
        reg2_d    = reg2_q;
        cnt_d     = '0;
        conta_d   = CONTA_MOSSE;
        timeout_d = 1'b0;
        if (ANNULLA) begin
            stato_d = VUOTO;
            reg1_d  = '0;
            reg2_d  = '0;
        end else begin
            unique case (stato_q)
                VUOTO: begin
                    if (v1) reg1_d = MOSSA_P1;
                    if (v2) reg2_d = MOSSA_P2;
                    if (v1 && v2)  stato_d = COMPLETO;
                    else if (v1)   stato_d = SOLO_P1;
                    else if (v2)   stato_d = SOLO_P2;
                end
                SOLO_P1: begin
                    if (v2) begin
                        reg2_d  = MOSSA_P2;
                        stato_d = COMPLETO;
                    end else if (cnt_q == SCADENZA) begin
                        reg2_d    = '0;
                        stato_d   = COMPLETO;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + 16'd1);
                    end
                end
                SOLO_P2: begin
                    if (v1) begin
                        reg1_d  = MOSSA_P1;
                        stato_d = COMPLETO;
                    end else if (cnt_q == SCADENZA) begin
                        reg1_d    = '0;
                        stato_d   = COMPLETO;
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + 16'd1);
                    end
                end
                COMPLETO: begin
                    if (PRONTO) begin
                        stato_d = VUOTO;
                        reg1_d  = '0;
                        reg2_d  = '0;
                        if (CONTA_MOSSE != CONTA_MAX)
                            conta_d = CONTA_W'(CONTA_MOSSE + 5'd1);
                    end
                end
                default: stato_d = VUOTO;
            endcase
        end
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stato_q       <= VUOTO;
            reg1_q        <= '0;
            reg2_q        <= '0;
            cnt_q         <= '0;
            PRIMO         <= '0;
            SECONDO       <= '0;
            USCITA_VALIDA <= 1'b0;
            ATTESA_P1     <= 1'b1;
            ATTESA_P2     <= 1'b1;
            TIMEOUT       <= 1'b0;
            CONTA_MOSSE   <= '0;
        end else begin
            stato_q       <= stato_d;
            reg1_q        <= reg1_d;
            reg2_q        <= reg2_d;
            cnt_q         <= cnt_d;
            PRIMO         <= (stato_d == COMPLETO) ? reg1_d : 2'b00;
            SECONDO       <= (stato_d == COMPLETO) ? reg2_d : 2'b00;
            USCITA_VALIDA <= (stato_d == COMPLETO);
            ATTESA_P1     <= (stato_d == VUOTO) || (stato_d == SOLO_P2);
            ATTESA_P2     <= (stato_d == VUOTO) || (stato_d == SOLO_P1);
            TIMEOUT       <= timeout_d;
            CONTA_MOSSE   <= conta_d;
        end
    end

endmodule

// File: tb/tb_raccolta_mosse.sv
// Directed bench for raccolta_mosse: per-cycle vector table plus saturation and async reset sequences.
module tb_raccolta_mosse;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] MOSSA_P1 = 2'b00;
    logic       VALIDO_P1 = 1'b0;
    logic [1:0] MOSSA_P2 = 2'b00;
    logic       VALIDO_P2 = 1'b0;
    logic       ANNULLA = 1'b0;
    logic       PRONTO = 1'b0;
    logic [1:0] PRIMO, SECONDO;
    logic       USCITA_VALIDA, ATTESA_P1, ATTESA_P2, TIMEOUT;
    logic [4:0] CONTA_MOSSE;

    int checks = 0;
    int failures = 0;

    raccolta_mosse #(.TIMEOUT_CICLI(16'd4)) dut (
        .clk(clk), .rst_n(rst_n),
        .MOSSA_P1(MOSSA_P1), .VALIDO_P1(VALIDO_P1),
        .MOSSA_P2(MOSSA_P2), .VALIDO_P2(VALIDO_P2),
        .ANNULLA(ANNULLA), .PRONTO(PRONTO),
        .PRIMO(PRIMO), .SECONDO(SECONDO), .USCITA_VALIDA(USCITA_VALIDA),
        .ATTESA_P1(ATTESA_P1), .ATTESA_P2(ATTESA_P2),
        .TIMEOUT(TIMEOUT), .CONTA_MOSSE(CONTA_MOSSE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] m1; logic v1; logic [1:0] m2; logic v2; logic ann; logic pr;
        logic [13:0] exp_o;  // {PRIMO, SECONDO, USCITA_VALIDA, ATTESA_P1, ATTESA_P2, TIMEOUT, CONTA_MOSSE}
    } vec_t;

    localparam int NV = 30;
    vec_t tab [NV];

    function automatic vec_t mk(logic [1:0] m1, logic v1, logic [1:0] m2, logic v2,
                                logic ann, logic pr, logic [1:0] p, logic [1:0] s,
                                logic uv, logic a1, logic a2, logic to, logic [4:0] cnt);
        vec_t r;
        r.m1 = m1; r.v1 = v1; r.m2 = m2; r.v2 = v2; r.ann = ann; r.pr = pr;
        r.exp_o = {p, s, uv, a1, a2, to, cnt};
        return r;
    endfunction

    function automatic logic [13:0] uscite();
        return {PRIMO, SECONDO, USCITA_VALIDA, ATTESA_P1, ATTESA_P2, TIMEOUT, CONTA_MOSSE};
    endfunction

    task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s got=%b expected=%b", name, act, exp_v);
        end
    endtask

    task automatic apply(input logic [1:0] m1, input logic v1, input logic [1:0] m2,
                         input logic v2, input logic ann, input logic pr);
        MOSSA_P1 = m1; VALIDO_P1 = v1; MOSSA_P2 = m2; VALIDO_P2 = v2;
        ANNULLA = ann; PRONTO = pr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //             m1    v1 m2    v2 an pr  p     s     uv a1 a2 to cnt
        tab[0]  = mk(2'b01, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 5'd0);
        tab[1]  = mk(2'b10, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 5'd0);
        tab[2]  = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 5'd0);
        tab[3]  = mk(2'b00, 0, 2'b11, 1, 0, 1, 2'b01, 2'b11, 1, 0, 0, 0, 5'd0);
        tab[4]  = mk(2'b00, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1, 0, 5'd1);
        tab[5]  = mk(2'b10, 1, 2'b10, 1, 0, 0, 2'b10, 2'b10, 1, 0, 0, 0, 5'd1);
        tab[6]  = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b10, 2'b10, 1, 0, 0, 0, 5'd1);
        tab[7]  = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b10, 2'b10, 1, 0, 0, 0, 5'd1);
        tab[8]  = mk(2'b11, 1, 2'b00, 0, 0, 0, 2'b10, 2'b10, 1, 0, 0, 0, 5'd1);
        tab[9]  = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b10, 2'b10, 1, 0, 0, 0, 5'd1);
        tab[10] = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b10, 2'b10, 1, 0, 0, 0, 5'd1);
        tab[11] = mk(2'b00, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1, 0, 5'd2);
        tab[12] = mk(2'b00, 0, 2'b10, 1, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 5'd2);
        tab[13] = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 5'd2);
        tab[14] = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 5'd2);
        tab[15] = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 5'd2);
        tab[16] = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 2'b10, 1, 0, 0, 1, 5'd2);
        tab[17] = mk(2'b00, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1, 0, 5'd3);
        tab[18] = mk(2'b00, 0, 2'b01, 1, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 5'd3);
        tab[19] = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 5'd3);
        tab[20] = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 5'd3);
        tab[21] = mk(2'b00, 0, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 0, 0, 5'd3);
        tab[22] = mk(2'b11, 1, 2'b00, 0, 0, 0, 2'b11, 2'b01, 1, 0, 0, 0, 5'd3);
        tab[23] = mk(2'b00, 0, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 1, 1, 0, 5'd4);
        tab[24] = mk(2'b00, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 5'd4);
        tab[25] = mk(2'b00, 0, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 5'd4);
        tab[26] = mk(2'b10, 1, 2'b01, 1, 0, 0, 2'b10, 2'b01, 1, 0, 0, 0, 5'd4);
        tab[27] = mk(2'b00, 0, 2'b00, 0, 1, 1, 2'b00, 2'b00, 0, 1, 1, 0, 5'd4);
        tab[28] = mk(2'b11, 1, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 5'd4);
        tab[29] = mk(2'b00, 0, 2'b01, 1, 1, 0, 2'b00, 2'b00, 0, 1, 1, 0, 5'd4);

        // Power-on reset, checked before any clock edge
        #1 rst_n = 1'b0;
        #2 check("reset_init", uscite(), {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            apply(tab[i].m1, tab[i].v1, tab[i].m2, tab[i].v2, tab[i].ann, tab[i].pr);
            check($sformatf("vec%0d", i), uscite(), tab[i].exp_o);
        end

        // 33 more transfers: count climbs from 4 and saturates at 31
        for (int i = 0; i < 33; i++) begin
            logic [4:0] exp_cnt;
            exp_cnt = (4 + i + 1 > 31) ? 5'd31 : 5'(4 + i + 1);
            apply(2'b01, 1, 2'b10, 1, 0, 0);
            apply(2'b00, 0, 2'b00, 0, 0, 1);
            if (i == 0 || i >= 26)
                check($sformatf("sat%0d", i), uscite(), {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, exp_cnt});
        end

        // Async reset mid-round, away from any clock edge
        apply(2'b11, 1, 2'b00, 0, 0, 0);
        check("solo_p1_pre_reset", uscite(), {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 5'd31});
        #2 rst_n = 1'b0;
        #1 check("reset_async", uscite(), {2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0});
        @(negedge clk);
        rst_n = 1'b1;
        apply(2'b00, 0, 2'b10, 1, 0, 1);
        check("post_reset_vuoto", uscite(), {2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/raccolta_mosse.md
RACCOLTA_MOSSE -- requirements
Module: raccolta_mosse

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CICLI, default 16'd1000, meaning the number of cycles to wait for the missing player's move before forfeit; legal range 1..65535.
REQ-002 The ports SHALL be, in order:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- MOSSA_P1  input  2  player 1 move: 01 sasso, 10 carta, 11 forbice, 00 none
- VALIDO_P1  input  1  MOSSA_P1 strobe
- MOSSA_P2  input  2  player 2 move, same encoding
- VALIDO_P2  input  1  MOSSA_P2 strobe
- ANNULLA  input  1  synchronous abort of the pending round
- PRONTO  input  1  downstream stage accepts the pair this cycle
- PRIMO  output  2  held player 1 move presented downstream
- SECONDO  output  2  held player 2 move presented downstream
- USCITA_VALIDA  output  1  PRIMO/SECONDO valid, pair awaiting transfer
- ATTESA_P1  output  1  player 1 move still missing
- ATTESA_P2  output  1  player 2 move still missing
- TIMEOUT  output  1  one-cycle pulse, round closed by forfeit
- CONTA_MOSSE  output  5  pairs transferred since reset, saturating
REQ-003 All outputs SHALL be registered.

Function
REQ-004 The FSM SHALL have states VUOTO, SOLO_P1, SOLO_P2, COMPLETO.
REQ-005 Move acceptance: a strobe SHALL count only when VALIDO_Px=1 and MOSSA_Px!=00; strobes with 00 are ignored.
REQ-006 VUOTO: P1 only -> latch into reg1, go to SOLO_P1. P2 only -> latch into reg2, go to SOLO_P2. Both in the same cycle -> latch both, go to COMPLETO.
REQ-007 SOLO_P1: a valid P2 move SHALL be latched and move to COMPLETO; further P1 strobes SHALL be ignored (first move locks). SOLO_P2 is symmetric.
REQ-008 Timeout counter: 16-bit, cleared on entry to SOLO_x, incremented each cycle in SOLO_x.
REQ-009 When the counter equals TIMEOUT_CICLI-1 and the missing move does not arrive that cycle, the block SHALL set the missing player's register to 00, go to COMPLETO, and pulse TIMEOUT for exactly that transition cycle.
REQ-010 If the missing move arrives in the same cycle as expiry, the move SHALL win: it is latched and TIMEOUT stays 0.
REQ-011 COMPLETO: USCITA_VALIDA=1, PRIMO=reg1, SECONDO=reg2, all held stable until PRONTO=1.
REQ-012 Transfer occurs on the rising edge with USCITA_VALIDA=1 and PRONTO=1. Next state SHALL be VUOTO, registers cleared to 00, and CONTA_MOSSE incremented, saturating at 31.
REQ-013 Strobes arriving in COMPLETO, including the transfer cycle, SHALL be ignored. Zero bubble is not required; the next round starts in VUOTO.
REQ-014 Outside COMPLETO, USCITA_VALIDA, PRIMO and SECONDO SHALL be 0.
REQ-015 ATTESA_P1=1 in VUOTO and SOLO_P2; ATTESA_P2=1 in VUOTO and SOLO_P1; both 0 in COMPLETO.
REQ-016 ANNULLA=1 in any state SHALL, at the next edge, force VUOTO, clear move registers and timeout counter, and suppress TIMEOUT and transfer, even with PRONTO=1. CONTA_MOSSE SHALL be unchanged. ANNULLA has priority over every other input.
REQ-017 PRONTO SHALL be ignored outside COMPLETO.

Reset
REQ-018 rst_n=0 SHALL immediately, without a clock, force state VUOTO, PRIMO=00, SECONDO=00, USCITA_VALIDA=0, ATTESA_P1=1, ATTESA_P2=1, TIMEOUT=0, CONTA_MOSSE=0, and the timeout counter to 0.
REQ-019 Reset asserted mid-round SHALL discard held moves; the first edge after deassertion evaluates inputs as in VUOTO.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- P1=01 at cycle 0, P2=11 at cycle 3, PRONTO=1 -> USCITA_VALIDA from cycle 4 for one cycle, PRIMO=01, SECONDO=11, CONTA_MOSSE=1.
- Both strobes same cycle (10, 10), PRONTO=0 for 5 cycles then 1 -> pair held stable 6 cycles; second P1 strobe 11 during hold ignored.
- TIMEOUT_CICLI=4, only P2=10 -> after 4 cycles in SOLO_P2, TIMEOUT pulse, PRIMO=00, SECONDO=10.
- TIMEOUT_CICLI=4, P1 move arrives on the expiry cycle -> no TIMEOUT, pair carries both moves.
- VALIDO_P1=1 with MOSSA_P1=00 -> no state change; ANNULLA in COMPLETO with PRONTO=1 -> VUOTO, CONTA_MOSSE unchanged.
- 33 transfers -> CONTA_MOSSE saturates at 31; rst_n low in SOLO_P1 -> all outputs at reset values asynchronously.
